// File: rtl/uart_tx_sched.sv
// uart_tx_sched: pops bytes from the tx FIFO and sends them 8N1 on tx.
// Ports: clk_i, reset_i (async, active-low), CSR write (csr_enable,
// csr_addr, rs1_data), FIFO side (have_next, fifo_data, next),
// line side (tx, busy), ctrl_out = {15'b0, enable, div_pending}.
module uart_tx_sched #(
   parameter int unsigned         DivWidth      = 16,
   parameter logic [DivWidth-1:0] DefaultDiv    = DivWidth'(234),
   parameter int unsigned         HoldoffCycles = 4,
   parameter logic [11:0]         CtrlCsrAddr   = 12'h7c0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        csr_enable,
   input  logic [11:0] csr_addr,
   input  logic [31:0] rs1_data,
   input  logic        have_next,
   input  logic [7:0]  fifo_data,
   output logic        next,
   output logic        tx,
   output logic        busy,
   output logic [31:0] ctrl_out
);

   localparam int HoW = (HoldoffCycles < 2) ? 1
                                            : $clog2(HoldoffCycles + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]          state;
   logic                enable;
   logic [DivWidth-1:0] div_pending;
   logic [DivWidth-1:0] div_active;
   logic [DivWidth-1:0] div_eff;
   logic [DivWidth-1:0] baud_cnt;
   logic [HoW-1:0]      holdoff;
   logic [2:0]          bit_idx;
   logic [7:0]          shreg;
   logic                csr_wr;
   logic                bit_end;
   logic                pop;
   logic                unused_bits;

   assign csr_wr  = csr_enable && (csr_addr == CtrlCsrAddr);
   assign div_eff = (div_pending == '0) ? DivWidth'(1) : div_pending;
   assign bit_end = (baud_cnt == div_active - DivWidth'(1));

   // Pop from IDLE, or on the last STOP cycle for back-to-back frames.
   assign pop = enable && have_next && (holdoff == '0) &&
                ((state == S_IDLE) ||
                 ((state == S_STOP) && bit_end));

   assign next     = pop;
   assign busy     = (state != S_IDLE);
   assign ctrl_out = {15'b0, enable, 16'(div_pending)};

   assign unused_bits = ^rs1_data[31:17];

   always_comb begin
      tx = 1'b1;
      case (state)
         S_START: tx = 1'b0;
         S_DATA:  tx = shreg[0];
         default: tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state       <= S_IDLE;
         enable      <= 1'b0;
         div_pending <= DefaultDiv;
         div_active  <= DefaultDiv;
         baud_cnt    <= '0;
         holdoff     <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
      end else begin
         if (csr_wr) begin
            div_pending <= rs1_data[DivWidth-1:0];
            enable      <= rs1_data[16];
         end

         if (pop) begin
            holdoff <= HoW'(HoldoffCycles);
         end else if (holdoff != '0) begin
            holdoff <= holdoff - HoW'(1);
         end

         // A same-cycle CSR write lands in div_pending after this
         // load, so the new divisor applies from the next frame.
         if (pop) begin
            shreg      <= fifo_data;
            div_active <= div_eff;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            state      <= S_START;
         end else if (state != S_IDLE) begin
            if (!bit_end) begin
               baud_cnt <= baud_cnt + DivWidth'(1);
            end else begin
               baud_cnt <= '0;
               case (state)
                  S_START: begin
                     bit_idx <= '0;
                     state   <= S_DATA;
                  end
                  S_DATA: begin
                     shreg   <= {1'b0, shreg[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                     if (bit_idx == 3'd7) begin
                        state <= S_STOP;
                     end
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: random and directed stimulus, queue scoreboard.
// A FIFO model feeds the DUT; a line monitor decodes every frame.
module tb_uart_tx_sched;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        csr_enable = 1'b0;
   logic [11:0] csr_addr = '0;
   logic [31:0] rs1_data = '0;
   logic        have_next = 1'b0;
   logic [7:0]  fifo_data = '0;
   logic        next;
   logic        tx;
   logic        busy;
   logic [31:0] ctrl_out;

   uart_tx_sched #(
      .DivWidth(16),
      .DefaultDiv(16'd234),
      .HoldoffCycles(4),
      .CtrlCsrAddr(12'h7c0)
   ) dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .csr_enable(csr_enable),
      .csr_addr(csr_addr),
      .rs1_data(rs1_data),
      .have_next(have_next),
      .fifo_data(fifo_data),
      .next(next),
      .tx(tx),
      .busy(busy),
      .ctrl_out(ctrl_out)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0] data;
      int         div;
      int         pop_cyc;
   } frame_t;

   frame_t     exp_q[$];
   logic [7:0] fifo_q[$];
   int         pop_cycles[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int lag = 0;
   int div_m = 234;
   bit en_m = 1'b0;
   int pops = 0;
   int busy_cyc = 0;
   bit mon_active = 1'b0;

   task automatic chk(input string name,
                      input logic [31:0] got,
                      input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
   end

   // FIFO model and scoreboard producer
   bit         sb_pop;
   frame_t     sb_f;
   initial forever begin
      @(negedge clk_i);
      sb_pop = 1'b0;
      if (reset_i === 1'b1 && next === 1'b1) begin
         chk("pop_have_next", {31'b0, have_next}, 1);
         chk("pop_enable", {31'b0, en_m}, 1);
         sb_f.data    = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
         sb_f.div     = (div_m == 0) ? 1 : div_m;
         sb_f.pop_cyc = cyc;
         exp_q.push_back(sb_f);
         pop_cycles.push_back(cyc);
         pops++;
         sb_pop = 1'b1;
      end
      @(posedge clk_i);
      #1;
      if (sb_pop && fifo_q.size() > 0) begin
         fifo_q.delete(0);
         lag = 3;
      end else if (lag > 0) begin
         lag--;
      end
      have_next = (lag == 0) && (fifo_q.size() > 0);
      fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
   end

   // Line monitor: decodes each frame against the expected queue
   frame_t     mon_e;
   int         mon_bad;
   int         mon_b;
   logic [7:0] mon_got;
   logic       mon_expb;
   bit         mon_abort;
   initial forever begin
      @(negedge clk_i);
      if (reset_i === 1'b1 && tx === 1'b0) begin
         mon_active = 1'b1;
         chk("start_has_pop", {31'b0, exp_q.size() > 0}, 1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_bad = 0;
            mon_got = '0;
            mon_abort = 1'b0;
            chk("start_latency", cyc - mon_e.pop_cyc, 1);
            for (int k = 0; k < 10 * mon_e.div; k++) begin
               if (k > 0) @(negedge clk_i);
               if (reset_i !== 1'b1) begin
                  mon_abort = 1'b1;
                  break;
               end
               mon_b = k / mon_e.div;
               if (mon_b == 0) mon_expb = 1'b0;
               else if (mon_b == 9) mon_expb = 1'b1;
               else mon_expb = mon_e.data[mon_b-1];
               if (tx !== mon_expb) mon_bad++;
               if (busy !== 1'b1) mon_bad++;
               if (mon_b >= 1 && mon_b <= 8 &&
                   (k % mon_e.div) == mon_e.div / 2)
                  mon_got[mon_b-1] = tx;
            end
            if (!mon_abort) begin
               chk("frame_shape", mon_bad, 0);
               chk("frame_data", {24'b0, mon_got},
                   {24'b0, mon_e.data});
            end
         end
         mon_active = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic csr_write(input logic [31:0] d);
      @(posedge clk_i);
      #1;
      csr_enable = 1'b1;
      csr_addr   = 12'h7c0;
      rs1_data   = d;
      @(posedge clk_i);
      #1;
      csr_enable = 1'b0;
      div_m = int'(d[15:0]);
      en_m  = d[16];
   endtask

   task automatic wait_pops(input int target, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk_i);
         #2;
         if (pops >= target) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_pop", {31'b0, ok}, 1);
   endtask

   task automatic drain(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk_i);
         #2;
         if (fifo_q.size() == 0 && exp_q.size() == 0 &&
             !mon_active && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("drain", {31'b0, ok}, 1);
   endtask

   int p0;
   int b0;
   int nb;
   int d;

   initial begin
      #1;
      chk("rst_tx", {31'b0, tx}, 1);
      chk("rst_next", {31'b0, next}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      repeat (3) @(negedge clk_i);
      reset_i = 1'b1;
      chk("rst_ctrl", ctrl_out, 32'h0000_00ea);

      // disabled: a waiting byte must not be popped
      fifo_q.push_back(8'h3c);
      p0 = pops;
      tick(1000);
      chk("idle_no_pop", pops - p0, 0);
      chk("idle_busy", {31'b0, busy}, 0);
      chk("idle_tx", {31'b0, tx}, 1);
      fifo_q.delete();
      tick(2);

      // single byte at divisor 4
      csr_write(32'h0001_0004);
      chk("ctrl_rb4", ctrl_out, 32'h0001_0004);
      p0 = pops;
      b0 = busy_cyc;
      fifo_q.push_back(8'ha5);
      wait_pops(p0 + 1, 50);
      drain(200);
      chk("single_pops", pops - p0, 1);
      chk("single_busy", busy_cyc - b0, 40);

      // back-to-back at divisor 1
      csr_write(32'h0000_0001);
      fifo_q.push_back(8'h00);
      fifo_q.push_back(8'hff);
      fifo_q.push_back(8'h55);
      tick(5);
      pop_cycles.delete();
      p0 = pops;
      b0 = busy_cyc;
      csr_write(32'h0001_0001);
      drain(200);
      chk("b2b_pops", pops - p0, 3);
      if (pop_cycles.size() == 3) begin
         chk("b2b_gap1", pop_cycles[1] - pop_cycles[0], 10);
         chk("b2b_gap2", pop_cycles[2] - pop_cycles[1], 10);
      end
      chk("b2b_busy", busy_cyc - b0, 30);

      // divisor change during DATA
      csr_write(32'h0000_0008);
      fifo_q.push_back(8'($urandom_range(0, 255)));
      fifo_q.push_back(8'($urandom_range(0, 255)));
      tick(5);
      pop_cycles.delete();
      p0 = pops;
      b0 = busy_cyc;
      csr_write(32'h0001_0008);
      wait_pops(p0 + 1, 50);
      tick(20);
      csr_write(32'h0001_0002);
      chk("ctrl_rb2", ctrl_out, 32'h0001_0002);
      drain(400);
      if (pop_cycles.size() == 2)
         chk("divchg_gap", pop_cycles[1] - pop_cycles[0], 80);
      chk("divchg_busy", busy_cyc - b0, 100);

      // divisor 0, then disable mid-frame
      csr_write(32'h0000_0000);
      for (int i = 0; i < 3; i++)
         fifo_q.push_back(8'($urandom_range(0, 255)));
      tick(5);
      p0 = pops;
      csr_write(32'h0001_0000);
      wait_pops(p0 + 1, 50);
      tick(3);
      csr_write(32'h0000_0000);
      tick(100);
      chk("dis_pops", pops - p0, 1);
      chk("dis_fifo", fifo_q.size(), 2);
      chk("dis_busy", {31'b0, busy}, 0);
      fifo_q.delete();
      tick(5);

      // random bursts with random divisor updates
      for (int r = 0; r < 6; r++) begin
         d = $urandom_range(0, 6);
         csr_write({15'b0, 1'b1, 16'(d)});
         nb = $urandom_range(1, 4);
         for (int i = 0; i < nb; i++)
            fifo_q.push_back(8'($urandom_range(0, 255)));
         tick($urandom_range(0, 30));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom_range(0, 6);
            csr_write({15'b0, 1'b1, 16'(d)});
         end
         drain(2000);
      end

      // async reset during DATA
      csr_write(32'h0000_0008);
      fifo_q.push_back(8'h81);
      fifo_q.push_back(8'h7e);
      tick(5);
      p0 = pops;
      csr_write(32'h0001_0008);
      wait_pops(p0 + 1, 50);
      tick(30);
      #2;
      reset_i = 1'b0;
      #1;
      chk("arst_tx", {31'b0, tx}, 1);
      chk("arst_busy", {31'b0, busy}, 0);
      chk("arst_next", {31'b0, next}, 0);
      exp_q.delete();
      en_m  = 1'b0;
      div_m = 234;
      tick(2);
      reset_i = 1'b1;
      chk("arst_ctrl", ctrl_out, 32'h0000_00ea);
      p0 = pops;
      tick(50);
      chk("arst_no_pop", pops - p0, 0);
      chk("arst_idle", {31'b0, busy}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
